aplic_latency_stats: RTL and testbench
======================================

Name: aplic_latency_stats

Overview:
- Downstream consumer of the APLIC latency counter.
- Captures each completed measurement (counter value at stop) and maintains running min/max/sum/count statistics.
- Buffers the most recent samples in a small FIFO, drained by a valid/ready reader such as a debug register bridge or trace sink.
- Raises a sticky flag when any sample exceeds a programmable threshold.

Parameters:
- DATA_W, 32, width of counter samples.
- SUM_W, 48, width of the accumulated sum.
- CNT_W, 16, width of the sample and drop counters.
- DEPTH, 8, FIFO depth in entries; power of two, ≥2.

Ports:
- clk_i  in  1  module clock.
- rst_i  in  1  synchronous, active-high reset.
- sample_i  in  DATA_W  counter value from the latency counter.
- sample_valid_i  in  1  single-cycle pulse: sample_i holds a completed measurement.
- clear_i  in  1  synchronous clear of stats, FIFO, flags.
- thresh_i  in  DATA_W  latency threshold, quasi-static.
- min_o  out  DATA_W  smallest sample seen.
- max_o  out  DATA_W  largest sample seen.
- sum_o  out  SUM_W  saturating sum of samples.
- sum_sat_o  out  1  sticky: sum saturated.
- count_o  out  CNT_W  saturating number of samples accepted.
- thresh_hit_o  out  1  sticky: some sample > thresh_i.
- rd_valid_o  out  1  FIFO non-empty.
- rd_data_o  out  DATA_W  FIFO head entry.
- rd_ready_i  in  1  reader accepts head.
- fifo_full_o  out  1  FIFO holds DEPTH entries.
- drop_cnt_o  out  CNT_W  saturating count of samples not pushed because FIFO was full.

Behaviour:
- Reset (rst_i=1 at posedge) and clear_i=1 have identical effect:
  - min_o = all-ones; max_o = 0; sum_o = 0; count_o = 0; drop_cnt_o = 0.
  - sum_sat_o = 0; thresh_hit_o = 0.
  - FIFO emptied: rd_valid_o = 0, fifo_full_o = 0, rd_data_o = 0.
- rst_i has priority over clear_i. clear_i has priority over a same-cycle sample and a same-cycle pop; the sample is discarded and the pop is ignored.
- Sample accept: on a posedge with sample_valid_i=1, all outputs reflect the sample after that edge (1-cycle latency). Per accepted sample:
  - min_o = min(min_o, sample_i); max_o = max(max_o, sample_i). The first sample after reset/clear therefore sets both.
  - Sum: sum_o += zero-extended sample_i. If the true sum exceeds 2^SUM_W-1, sum_o holds at all-ones and sum_sat_o is set. Once saturated, sum_o stays all-ones.
  - count_o += 1, saturating at all-ones.
  - thresh_hit_o set if sample_i > thresh_i (strict, unsigned). The flag is sticky until reset/clear.
- FIFO:
  - Circular buffer with log2(DEPTH)-bit read/write pointers plus a separate occupancy counter (0..DEPTH).
  - Push when sample_valid_i=1 and (not full, or pop in same cycle).
  - Pop when rd_valid_o & rd_ready_i. Pointers wrap modulo DEPTH.
  - Full with no same-cycle pop: sample not stored, drop_cnt_o += 1 (saturating). Stats still update.
  - Simultaneous push+pop when full: both occur, occupancy unchanged, no drop.
  - Simultaneous push+pop when empty: rd_valid_o=0, so no pop; push occurs.
  - rd_data_o registered-head semantics: equals the oldest entry while rd_valid_o=1. It is stable while rd_ready_i=0. Value is don't-care when empty (0 after reset).
  - rd_ready_i with rd_valid_o=0 has no effect.
- Back-to-back sample_valid_i pulses on consecutive cycles are all accepted; no bubble is required.
- No combinational path from any input to any output.

Test Plan:
- Reset/idle: assert rst_i 2 cycles → min_o=0xFFFFFFFF, max_o=0, sum_o=0, count_o=0, rd_valid_o=0, flags 0.
- Stats: with thresh_i=40, samples 25, 10, 50 on consecutive cycles → min_o=10, max_o=50, sum_o=85, count_o=3, thresh_hit_o=1 one cycle after the 50.
- FIFO overflow: DEPTH=8, rd_ready_i=0, push 10 samples 1..10 → fifo_full_o=1, drop_cnt_o=2, count_o=10. Then drain with rd_ready_i=1 → reads 1..8 in order, then rd_valid_o=0.
- Full push+pop: fill to 8 entries, then sample 99 with rd_ready_i=1 in the same cycle → head 1 popped, 99 stored, drop_cnt_o unchanged, fifo_full_o stays 1.
- Sum saturation: SUM_W=33, two samples of 0xFFFFFFFF plus sample 5 → sum_o=0x1FFFFFFFF, sum_sat_o=1 and remains set.
- Clear priority: clear_i and sample_valid_i (sample 7) in the same cycle after prior data → all stats at reset values, count_o=0, FIFO empty.

Source files
------------

// File: rtl/aplic_latency_stats.sv
// APLIC latency statistics: running min/max/sum/count over completed
// measurements, a small sample FIFO for a reader, and a sticky threshold flag.
module aplic_latency_stats #(
    parameter int DATA_W = 32,
    parameter int SUM_W  = 48,
    parameter int CNT_W  = 16,
    parameter int DEPTH  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] sample_i,
    input  logic              sample_valid_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] thresh_i,
    output logic [DATA_W-1:0] min_o,
    output logic [DATA_W-1:0] max_o,
    output logic [SUM_W-1:0]  sum_o,
    output logic              sum_sat_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              thresh_hit_o,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              rd_ready_i,
    output logic              fifo_full_o,
    output logic [CNT_W-1:0]  drop_cnt_o
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] min_q, min_d, max_q, max_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic              sum_sat_q, sum_sat_d;
    logic [CNT_W-1:0]  count_q, count_d, drop_q, drop_d;
    logic              thresh_hit_q, thresh_hit_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]       occ_q, occ_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              full, pop, push;
    logic [SUM_W:0]    sum_ext;

    always_comb begin
        min_d        = min_q;
        max_d        = max_q;
        sum_d        = sum_q;
        sum_sat_d    = sum_sat_q;
        count_d      = count_q;
        thresh_hit_d = thresh_hit_q;
        drop_d       = drop_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        full         = (occ_q == (PW+1)'(DEPTH));
        pop          = (occ_q != '0) && rd_ready_i;
        push         = sample_valid_i && (!full || pop);
        sum_ext      = {1'b0, sum_q} + (SUM_W+1)'(sample_i);

        if (clear_i) begin
            min_d        = '1;
            max_d        = '0;
            sum_d        = '0;
            sum_sat_d    = 1'b0;
            count_d      = '0;
            thresh_hit_d = 1'b0;
            drop_d       = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            occ_d        = '0;
            pop          = 1'b0;
            push         = 1'b0;
        end else begin
            if (sample_valid_i) begin
                if (sample_i < min_q) min_d = sample_i;
                if (sample_i > max_q) max_d = sample_i;
                // Carry out of the widened add means the true sum overflowed
                if (sum_ext[SUM_W]) begin
                    sum_d     = '1;
                    sum_sat_d = 1'b1;
                end else begin
                    sum_d = sum_ext[SUM_W-1:0];
                end
                if (count_q != '1) count_d = count_q + CNT_W'(1);
                if (sample_i > thresh_i) thresh_hit_d = 1'b1;
                if (!push && drop_q != '1) drop_d = drop_q + CNT_W'(1);
            end
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      occ_d = occ_q + (PW+1)'(1);
            else if (pop && !push) occ_d = occ_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            min_q        <= '1;
            max_q        <= '0;
            sum_q        <= '0;
            sum_sat_q    <= 1'b0;
            count_q      <= '0;
            thresh_hit_q <= 1'b0;
            drop_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
        end else begin
            min_q        <= min_d;
            max_q        <= max_d;
            sum_q        <= sum_d;
            sum_sat_q    <= sum_sat_d;
            count_q      <= count_d;
            thresh_hit_q <= thresh_hit_d;
            drop_q       <= drop_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push) mem_q[wr_ptr_q] <= sample_i;
    end

    assign min_o        = min_q;
    assign max_o        = max_q;
    assign sum_o        = sum_q;
    assign sum_sat_o    = sum_sat_q;
    assign count_o      = count_q;
    assign thresh_hit_o = thresh_hit_q;
    assign drop_cnt_o   = drop_q;
    assign rd_valid_o   = (occ_q != '0);
    assign fifo_full_o  = (occ_q == (PW+1)'(DEPTH));
    // Head is masked to zero when empty so stale storage never shows
    assign rd_data_o    = rd_valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_aplic_latency_stats.sv
// Self-checking bench for aplic_latency_stats against a queue-based
// reference model of the statistics and sample FIFO.
module tb_aplic_latency_stats;

    localparam int DATA_W = 32;
    localparam int SUM_W  = 33;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 8;
    localparam longint SUM_MAX = (longint'(1) << SUM_W) - 1;
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic [DATA_W-1:0] sample_i = '0;
    logic              sample_valid_i = 1'b0;
    logic              clear_i = 1'b0;
    logic [DATA_W-1:0] thresh_i = '0;
    logic [DATA_W-1:0] min_o, max_o, rd_data_o;
    logic [SUM_W-1:0]  sum_o;
    logic              sum_sat_o, thresh_hit_o, rd_valid_o, fifo_full_o;
    logic [CNT_W-1:0]  count_o, drop_cnt_o;
    logic              rd_ready_i = 1'b0;

    aplic_latency_stats #(
        .DATA_W(DATA_W), .SUM_W(SUM_W), .CNT_W(CNT_W), .DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .sample_i(sample_i),
        .sample_valid_i(sample_valid_i), .clear_i(clear_i),
        .thresh_i(thresh_i), .min_o(min_o), .max_o(max_o),
        .sum_o(sum_o), .sum_sat_o(sum_sat_o), .count_o(count_o),
        .thresh_hit_o(thresh_hit_o), .rd_valid_o(rd_valid_o),
        .rd_data_o(rd_data_o), .rd_ready_i(rd_ready_i),
        .fifo_full_o(fifo_full_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    longint m_min, m_max, m_sum, m_cnt, m_drop;
    bit     m_sat, m_hit;
    longint m_q[$];

    task automatic model_clear();
        m_min = 64'hFFFF_FFFF; m_max = 0; m_sum = 0; m_cnt = 0; m_drop = 0;
        m_sat = 0; m_hit = 0;
        m_q.delete();
    endtask

    task automatic cycle(input bit sv, input longint s,
                         input bit rr, input bit clr);
        sample_valid_i = sv;
        sample_i       = s[DATA_W-1:0];
        rd_ready_i     = rr;
        clear_i        = clr;
        if (clr) begin
            model_clear();
        end else begin
            if (rr && m_q.size() > 0) void'(m_q.pop_front());
            if (sv) begin
                if (m_q.size() < DEPTH) m_q.push_back(s);
                else if (m_drop < CNT_MAX) m_drop++;
                if (s < m_min) m_min = s;
                if (s > m_max) m_max = s;
                m_sum = m_sum + s;
                if (m_sum > SUM_MAX) begin m_sum = SUM_MAX; m_sat = 1; end
                if (m_cnt < CNT_MAX) m_cnt++;
                if (s > longint'(thresh_i)) m_hit = 1;
            end
        end
        @(posedge clk); #1;
        sample_valid_i = 0; rd_ready_i = 0; clear_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 1;
        repeat (2) @(posedge clk);
        #1 rst_i = 0;
        model_clear();
        checks++;
        if (min_o !== 32'hFFFF_FFFF || max_o !== 0 || sum_o !== 0 ||
            count_o !== 0 || drop_cnt_o !== 0) begin
            fails++;
            $display("FAIL reset_stats: min=%h max=%h sum=%h cnt=%0d drop=%0d, need ffffffff/0/0/0/0",
                     min_o, max_o, sum_o, count_o, drop_cnt_o);
        end
        checks++;
        if (rd_valid_o !== 0 || fifo_full_o !== 0 || rd_data_o !== 0 ||
            sum_sat_o !== 0 || thresh_hit_o !== 0) begin
            fails++;
            $display("FAIL reset_flags: valid=%b full=%b data=%h sat=%b hit=%b, need 0",
                     rd_valid_o, fifo_full_o, rd_data_o, sum_sat_o, thresh_hit_o);
        end
    endtask

    task automatic test_stats();
        thresh_i = 40;
        cycle(1, 25, 0, 0);
        checks++;
        if (thresh_hit_o !== 0) begin
            fails++; $display("FAIL stats_nohit: hit=%b need 0", thresh_hit_o);
        end
        cycle(1, 10, 0, 0);
        cycle(1, 50, 0, 0);
        checks++;
        if (min_o !== 10 || max_o !== 50 || sum_o !== 85 || count_o !== 3 ||
            thresh_hit_o !== 1) begin
            fails++;
            $display("FAIL stats: min=%0d max=%0d sum=%0d cnt=%0d hit=%b, need 10/50/85/3/1",
                     min_o, max_o, sum_o, count_o, thresh_hit_o);
        end
        checks++;
        if (longint'(min_o) !== m_min || longint'(sum_o) !== m_sum) begin
            fails++;
            $display("FAIL stats_model: min=%0d sum=%0d, need %0d/%0d",
                     min_o, sum_o, m_min, m_sum);
        end
    endtask

    task automatic test_overflow();
        cycle(0, 0, 0, 1);
        for (int i = 1; i <= 10; i++) cycle(1, i, 0, 0);
        checks++;
        if (fifo_full_o !== 1 || drop_cnt_o !== 2 || count_o !== 10) begin
            fails++;
            $display("FAIL overflow: full=%b drop=%0d cnt=%0d, need 1/2/10",
                     fifo_full_o, drop_cnt_o, count_o);
        end
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (rd_valid_o !== 1 || longint'(rd_data_o) !== m_q[0] ||
                rd_data_o !== DATA_W'(i)) begin
                fails++;
                $display("FAIL drain_%0d: valid=%b data=%0d, need 1/%0d",
                         i, rd_valid_o, rd_data_o, i);
            end
            cycle(0, 0, 1, 0);
        end
        checks++;
        if (rd_valid_o !== 0 || fifo_full_o !== 0) begin
            fails++;
            $display("FAIL drain_empty: valid=%b full=%b, need 0/0",
                     rd_valid_o, fifo_full_o);
        end
    endtask

    task automatic test_full_push_pop();
        cycle(0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) cycle(1, i, 0, 0);
        cycle(1, 99, 1, 0);
        checks++;
        if (fifo_full_o !== 1 || drop_cnt_o !== 0 || rd_data_o !== 2) begin
            fails++;
            $display("FAIL full_push_pop: full=%b drop=%0d head=%0d, need 1/0/2",
                     fifo_full_o, drop_cnt_o, rd_data_o);
        end
        for (int i = 0; i < 7; i++) cycle(0, 0, 1, 0);
        checks++;
        if (rd_valid_o !== 1 || rd_data_o !== 99) begin
            fails++;
            $display("FAIL full_push_pop_tail: valid=%b data=%0d, need 1/99",
                     rd_valid_o, rd_data_o);
        end
    endtask

    task automatic test_sum_sat();
        cycle(0, 0, 0, 1);
        thresh_i = '1;
        cycle(1, 64'hFFFF_FFFF, 0, 0);
        cycle(1, 64'hFFFF_FFFF, 0, 0);
        checks++;
        if (sum_o !== 33'h1_FFFF_FFFE || sum_sat_o !== 0) begin
            fails++;
            $display("FAIL sum_near: sum=%h sat=%b, need 1fffffffe/0", sum_o, sum_sat_o);
        end
        cycle(1, 5, 0, 0);
        checks++;
        if (sum_o !== 33'h1_FFFF_FFFF || sum_sat_o !== 1) begin
            fails++;
            $display("FAIL sum_sat: sum=%h sat=%b, need 1ffffffff/1", sum_o, sum_sat_o);
        end
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        checks++;
        if (sum_o !== 33'h1_FFFF_FFFF || sum_sat_o !== 1 || thresh_hit_o !== 0) begin
            fails++;
            $display("FAIL sum_sticky: sum=%h sat=%b hit=%b, need 1ffffffff/1/0",
                     sum_o, sum_sat_o, thresh_hit_o);
        end
    endtask

    task automatic test_clear();
        thresh_i = 3;
        cycle(1, 20, 0, 0);
        cycle(1, 7, 1, 1);
        checks++;
        if (min_o !== 32'hFFFF_FFFF || max_o !== 0 || sum_o !== 0 ||
            count_o !== 0 || drop_cnt_o !== 0 || sum_sat_o !== 0 ||
            thresh_hit_o !== 0 || rd_valid_o !== 0 || fifo_full_o !== 0) begin
            fails++;
            $display("FAIL clear: min=%h max=%0d sum=%0d cnt=%0d drop=%0d sat=%b hit=%b valid=%b full=%b, need reset values",
                     min_o, max_o, sum_o, count_o, drop_cnt_o, sum_sat_o,
                     thresh_hit_o, rd_valid_o, fifo_full_o);
        end
    endtask

    task automatic test_random();
        cycle(0, 0, 0, 1);
        thresh_i = DATA_W'($urandom_range(500, 900));
        for (int n = 0; n < 400; n++) begin
            longint s;
            s = ($urandom_range(0, 15) == 0) ? longint'($urandom)
                                             : longint'($urandom_range(0, 1000));
            cycle($urandom_range(0, 3) != 0, s, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 60) == 0);
            checks++;
            if (longint'(min_o) !== m_min || longint'(max_o) !== m_max ||
                longint'(sum_o) !== m_sum || sum_sat_o !== m_sat ||
                longint'(count_o) !== m_cnt || thresh_hit_o !== m_hit) begin
                fails++;
                $display("FAIL rand_stats_%0d: min=%0d max=%0d sum=%0d sat=%b cnt=%0d hit=%b, need %0d/%0d/%0d/%b/%0d/%b",
                         n, min_o, max_o, sum_o, sum_sat_o, count_o, thresh_hit_o,
                         m_min, m_max, m_sum, m_sat, m_cnt, m_hit);
            end
            checks++;
            if (rd_valid_o !== (m_q.size() > 0) ||
                fifo_full_o !== (m_q.size() == DEPTH) ||
                longint'(drop_cnt_o) !== m_drop ||
                (m_q.size() > 0 && longint'(rd_data_o) !== m_q[0])) begin
                fails++;
                $display("FAIL rand_fifo_%0d: valid=%b full=%b drop=%0d data=%0d, need occ=%0d drop=%0d",
                         n, rd_valid_o, fifo_full_o, drop_cnt_o, rd_data_o,
                         m_q.size(), m_drop);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_stats();
        test_overflow();
        test_full_push_pop();
        test_sum_sat();
        test_clear();
        test_random();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
